// File: rtl/regfile_xfer_ctrl.sv
// Register-file transfer master: DUMP streams r0..r(NUM_REGS-1) out over
// valid/ready, LOAD writes NUM_REGS streamed words into the RF.
// Optional build macro: REGFILE_XFER_CSUM_EN adds a trailing XOR checksum
// word to both directions and a load_err output.
module regfile_xfer_ctrl #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_start,
  input  logic              load_start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready
`ifdef REGFILE_XFER_CSUM_EN
  ,
  output logic              load_err
`endif
);

  localparam int unsigned     CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DUMP_RD = 3'd1,
    DUMP_TX = 3'd2,
    LOAD    = 3'd3,
    FIN     = 3'd4
`ifdef REGFILE_XFER_CSUM_EN
    ,
    CSUM_TX = 3'd5,
    CSUM_RX = 3'd6
`endif
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              busy_nxt, done_nxt, in_ready_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt, wr_addr_nxt;
  logic              wr_en_nxt, out_valid_nxt;
  logic [DATA_W-1:0] wr_data_nxt, out_data_nxt;
`ifdef REGFILE_XFER_CSUM_EN
  logic [DATA_W-1:0] csum, csum_nxt;
  logic              load_err_nxt;
`endif

  // State and registered outputs; reset aborts any operation immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rf_rd_addr <= '0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b0;
`ifdef REGFILE_XFER_CSUM_EN
      csum       <= '0;
      load_err   <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      rf_rd_addr <= rd_addr_nxt;
      rf_wr_en   <= wr_en_nxt;
      rf_wr_addr <= wr_addr_nxt;
      rf_wr_data <= wr_data_nxt;
      out_data   <= out_data_nxt;
      out_valid  <= out_valid_nxt;
      in_ready   <= in_ready_nxt;
`ifdef REGFILE_XFER_CSUM_EN
      csum       <= csum_nxt;
      load_err   <= load_err_nxt;
`endif
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    wr_en_nxt     = 1'b0;
    wr_addr_nxt   = rf_wr_addr;
    wr_data_nxt   = rf_wr_data;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
`ifdef REGFILE_XFER_CSUM_EN
    csum_nxt      = csum;
    load_err_nxt  = load_err;
`endif
    case (state)
      IDLE: begin
        if (dump_start || load_start) begin
          state_nxt = dump_start ? DUMP_RD : LOAD;
          cnt_nxt   = '0;
`ifdef REGFILE_XFER_CSUM_EN
          csum_nxt     = '0;
          load_err_nxt = 1'b0;
`endif
        end
      end
      DUMP_RD: begin
        out_data_nxt  = rf_rd_data;
        out_valid_nxt = 1'b1;
        state_nxt     = DUMP_TX;
      end
      DUMP_TX: begin
        if (out_valid && out_ready) begin
          out_valid_nxt = 1'b0;
`ifdef REGFILE_XFER_CSUM_EN
          csum_nxt = csum ^ out_data;
`endif
          if (cnt == CNT_LAST) begin
`ifdef REGFILE_XFER_CSUM_EN
            state_nxt = CSUM_TX;
`else
            state_nxt = FIN;
`endif
          end else begin
            cnt_nxt   = cnt + CNT_W'(1);
            state_nxt = DUMP_RD;
          end
        end
      end
      LOAD: begin
        if (in_valid && in_ready) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = cnt[ADDR_W-1:0];
          wr_data_nxt = in_data;
`ifdef REGFILE_XFER_CSUM_EN
          csum_nxt = csum ^ in_data;
`endif
          if (cnt == CNT_LAST) begin
`ifdef REGFILE_XFER_CSUM_EN
            state_nxt = CSUM_RX;
`else
            state_nxt = FIN;
`endif
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
`ifdef REGFILE_XFER_CSUM_EN
      // First cycle presents the checksum, then waits for the handshake
      CSUM_TX: begin
        if (!out_valid) begin
          out_data_nxt  = csum;
          out_valid_nxt = 1'b1;
        end else if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = FIN;
        end
      end
      CSUM_RX: begin
        if (in_valid && in_ready) begin
          load_err_nxt = (in_data != csum);
          state_nxt    = FIN;
        end
      end
`endif
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt    = (state_nxt != IDLE);
    done_nxt    = (state_nxt == FIN);
    rd_addr_nxt = ((state_nxt == DUMP_RD) || (state_nxt == DUMP_TX)) ? cnt_nxt[ADDR_W-1:0] : '0;
`ifdef REGFILE_XFER_CSUM_EN
    in_ready_nxt = (state_nxt == LOAD) || (state_nxt == CSUM_RX);
`else
    in_ready_nxt = (state_nxt == LOAD);
`endif
  end

endmodule

// File: tb/tb_regfile_xfer_ctrl.sv
// Self-checking bench for regfile_xfer_ctrl with a behavioural 16x16 RF model
// and scoreboard queues for the dump stream and the RF write port.
`timescale 1ns/1ps
module tb_regfile_xfer_ctrl;

`ifdef REGFILE_XFER_CSUM_EN
  localparam int DUMP_CYC = 34;
  localparam int N_OUT    = 17;
`else
  localparam int DUMP_CYC = 32;
  localparam int N_OUT    = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        dump_start = 1'b0, load_start = 1'b0;
  logic        busy, done;
  logic [3:0]  rf_rd_addr, rf_wr_addr;
  logic [15:0] rf_rd_data, rf_wr_data, out_data;
  logic        rf_wr_en, out_valid, in_ready;
  logic        out_ready = 1'b0, in_valid = 1'b0;
  logic [15:0] in_data = '0;
`ifdef REGFILE_XFER_CSUM_EN
  logic        load_err;
`endif

  int checks = 0, errors = 0;
  int done_cnt = 0, wr_cnt = 0, hs_cnt = 0;
  logic [15:0] exp_out[$];
  logic [19:0] exp_wr[$];
  logic [15:0] rf [16];
  logic [15:0] vals [16];
  logic        preset_req = 1'b0;
  logic        stall_q = 1'b0;
  logic [15:0] stall_data = '0;
  logic [19:0] mon_e;
  logic [15:0] mon_o;
  int n, d0, w0, h0, k;

  always #5 clk = ~clk;

  regfile_xfer_ctrl dut (
    .clk(clk), .rst_n(rst_n), .dump_start(dump_start), .load_start(load_start),
    .busy(busy), .done(done), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
`ifdef REGFILE_XFER_CSUM_EN
    , .load_err(load_err)
`endif
  );

  // Register file model: combinational read, clocked write
  assign rf_rd_data = rf[rf_rd_addr];
  always @(posedge clk) begin
    if (preset_req) for (int i = 0; i < 16; i++) rf[i] <= 16'(i);
    else if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pops for writes and stream words, stall stability
  initial forever begin
    @(negedge clk);
    if (!rst_n) stall_q = 1'b0;
    else begin
      if (done) done_cnt++;
      if (rf_wr_en) begin
        wr_cnt++;
        chk("wr_expected", 32'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) begin
          mon_e = exp_wr.pop_front();
          chk("wr_addr", 32'(rf_wr_addr), 32'(mon_e[19:16]));
          chk("wr_data", 32'(rf_wr_data), 32'(mon_e[15:0]));
        end
      end
      if (stall_q) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data", 32'(out_data), 32'(stall_data));
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        chk("out_expected", 32'(exp_out.size() != 0), 1);
        if (exp_out.size() != 0) begin
          mon_o = exp_out.pop_front();
          chk("out_data", 32'(out_data), 32'(mon_o));
        end
      end
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_dump();
    logic [15:0] x;
    x = '0;
    for (int i = 0; i < 16; i++) begin
      exp_out.push_back(vals[i]);
      x = x ^ vals[i];
    end
`ifdef REGFILE_XFER_CSUM_EN
    exp_out.push_back(x);
`endif
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 400) begin tick(); cyc++; end
    chk("done_seen", 32'(done), 1);
  endtask

  task automatic feed(input logic [15:0] d);
    logic acc;
    int t;
    in_valid = 1'b1; in_data = d; t = 0;
    do begin
      @(negedge clk); acc = in_ready;
      tick(); t++;
    end while (!acc && t < 50);
    in_valid = 1'b0;
    chk("feed_accept", 32'(acc), 1);
  endtask

  // Full LOAD of 0xBASE+i with gaps; trailing checksum word when enabled
  task automatic do_load(input logic [15:0] base, input logic bad_csum);
    logic [15:0] x;
    x = '0;
    for (int i = 0; i < 16; i++) exp_wr.push_back({4'(i), 16'(base + 16'(i))});
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i % 3 == 1) tick();
      feed(16'(base + 16'(i)));
      x = x ^ 16'(base + 16'(i));
    end
`ifdef REGFILE_XFER_CSUM_EN
    feed(bad_csum ? ~x : x);
`else
    if (bad_csum) x = '0;
`endif
  endtask

  initial begin
    #1 rst_n = 1'b0;
    preset_req = 1'b1;
    repeat (3) tick();
    preset_req = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_wr_en", 32'(rf_wr_en), 0);
    chk("rst_wr_addr", 32'(rf_wr_addr), 0);
    chk("rst_wr_data", 32'(rf_wr_data), 0);
    chk("rst_rd_addr", 32'(rf_rd_addr), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    tick();

    // 1: dump of preset RF, ready tied high
    for (int i = 0; i < 16; i++) vals[i] = 16'(i);
    push_dump();
    out_ready = 1'b1; d0 = done_cnt; w0 = wr_cnt; h0 = hs_cnt;
    dump_start = 1'b1; tick(); dump_start = 1'b0;
    wait_done(n);
    chk("t1_latency", 32'(n), 32'(DUMP_CYC));
    chk("t1_busy_at_done", 32'(busy), 1);
    tick();
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_done_once", 32'(done_cnt - d0), 1);
    chk("t1_words", 32'(hs_cnt - h0), 32'(N_OUT));
    chk("t1_queue", 32'(exp_out.size()), 0);
    chk("t1_no_wr", 32'(wr_cnt - w0), 0);

    // 2: dump with ready high one cycle in three
    push_dump();
    out_ready = 1'b0; h0 = hs_cnt; d0 = done_cnt;
    dump_start = 1'b1; tick(); dump_start = 1'b0;
    k = 0;
    while (!done && k < 400) begin out_ready = (k % 3 == 0); tick(); k++; end
    out_ready = 1'b1;
    chk("t2_done", 32'(done), 1);
    tick();
    chk("t2_words", 32'(hs_cnt - h0), 32'(N_OUT));
    chk("t2_queue", 32'(exp_out.size()), 0);
    chk("t2_done_once", 32'(done_cnt - d0), 1);

    // 3: gapped load of 0xA000+i, then RF contents
    w0 = wr_cnt; d0 = done_cnt;
    do_load(16'hA000, 1'b0);
    wait_done(n);
    tick();
    chk("t3_wr_pulses", 32'(wr_cnt - w0), 16);
    chk("t3_queue", 32'(exp_wr.size()), 0);
    chk("t3_done_once", 32'(done_cnt - d0), 1);
    for (int i = 0; i < 16; i++) chk("t3_rf", 32'(rf[i]), 32'(16'hA000 + 16'(i)));

    // 4: simultaneous starts -> dump; starts while busy are ignored
    for (int i = 0; i < 16; i++) vals[i] = 16'hA000 + 16'(i);
    push_dump();
    w0 = wr_cnt; d0 = done_cnt;
    dump_start = 1'b1; load_start = 1'b1; tick();
    dump_start = 1'b0; load_start = 1'b0;
    n = 0;
    while (!done && n < 400) begin
      load_start = (n == 5 || n == 12);
      dump_start = (n == 11 || n == 12);
      tick(); n++;
    end
    load_start = 1'b0; dump_start = 1'b0;
    chk("t4_latency", 32'(n), 32'(DUMP_CYC));
    tick();
    chk("t4_idle", 32'(busy), 0);
    chk("t4_no_wr", 32'(wr_cnt - w0), 0);
    chk("t4_queue", 32'(exp_out.size()), 0);
    chk("t4_done_once", 32'(done_cnt - d0), 1);

    // 5a: reset while word 7 is stalled in DUMP_TX
    push_dump();
    d0 = done_cnt; h0 = hs_cnt; out_ready = 1'b1;
    dump_start = 1'b1; tick(); dump_start = 1'b0;
    k = 0;
    while (hs_cnt - h0 < 7 && k < 400) begin tick(); k++; end
    out_ready = 1'b0;
    k = 0;
    while (!out_valid && k < 10) begin tick(); k++; end
    chk("t5_w7_valid", 32'(out_valid), 1);
    chk("t5_w7_data", 32'(out_data), 32'(16'hA007));
    #2 rst_n = 1'b0;
    #1;
    chk("t5a_out_valid", 32'(out_valid), 0);
    chk("t5a_out_data", 32'(out_data), 0);
    chk("t5a_busy", 32'(busy), 0);
    chk("t5a_rd_addr", 32'(rf_rd_addr), 0);
    exp_out.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("t5a_no_done", 32'(done_cnt - d0), 0);

    // 5b: reset during LOAD while word 4 write is pending and word 5 offered
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) exp_wr.push_back({4'(i), 16'h5500 + 16'(i)});
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 5; i++) feed(16'h5500 + 16'(i));
    chk("t5b_wr_pending", 32'(rf_wr_en), 1);
    in_valid = 1'b1; in_data = 16'h5505;
    #1 rst_n = 1'b0;
    #1;
    chk("t5b_wr_en", 32'(rf_wr_en), 0);
    chk("t5b_wr_addr", 32'(rf_wr_addr), 0);
    chk("t5b_wr_data", 32'(rf_wr_data), 0);
    chk("t5b_in_ready", 32'(in_ready), 0);
    chk("t5b_busy", 32'(busy), 0);
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("t5b_rf3", 32'(rf[3]), 32'(16'h5503));
    chk("t5b_rf4", 32'(rf[4]), 32'(16'hA004));
    chk("t5b_rf5", 32'(rf[5]), 32'(16'hA005));
    chk("t5b_queue", 32'(exp_wr.size()), 0);
    chk("t5b_no_done", 32'(done_cnt - d0), 0);

    // 5c: fresh dump restarts at r0
    for (int i = 0; i < 16; i++) vals[i] = (i < 4) ? 16'h5500 + 16'(i) : 16'hA000 + 16'(i);
    push_dump();
    out_ready = 1'b1; h0 = hs_cnt;
    dump_start = 1'b1; tick(); dump_start = 1'b0;
    wait_done(n);
    chk("t5c_latency", 32'(n), 32'(DUMP_CYC));
    tick();
    chk("t5c_words", 32'(hs_cnt - h0), 32'(N_OUT));
    chk("t5c_queue", 32'(exp_out.size()), 0);

`ifdef REGFILE_XFER_CSUM_EN
    // 6: checksum mismatch flags load_err at done, a matching load clears it
    do_load(16'h3C00, 1'b1);
    wait_done(n);
    chk("t6_err_bad", 32'(load_err), 1);
    tick();
    do_load(16'h3C00, 1'b0);
    wait_done(n);
    chk("t6_err_good", 32'(load_err), 0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
